uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that shares the single UART transmitter among NUM_REQ byte-stream requesters.
- Sits between the requesters and the UART top's send/dintx/donetx interface.
- A requester owns the transmitter for a whole burst, which ends at a byte tagged last.
- An inter-byte gap watchdog stops a stalled owner from locking the transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_GAP, 64, cycles an owner may leave req_valid low inside a burst before its grant is revoked.
- ID_W, $clog2(NUM_REQ), width of grant_id.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  8*NUM_REQ  byte for requester i on bits [8i+7:8i].
- req_last  input  NUM_REQ  byte is the final byte of the burst.
- req_ready  output  NUM_REQ  one-hot accept; a byte transfers when valid&ready in the same cycle.
- uart_send  output  1  one-cycle start pulse to the UART transmitter.
- uart_dintx  output  8  byte to the UART transmitter.
- uart_donetx  input  1  one-cycle pulse from the UART transmitter when the frame is complete.
- grant_id  output  ID_W  index of the current owner; valid while busy=1.
- busy  output  1  high from the first byte accept until the burst is released.
- gap_err  output  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (rst=0, async): state=IDLE; req_ready=0; uart_send=0; uart_dintx=8'h00; grant_id=0; busy=0; gap_err=0; last_grant=NUM_REQ-1, so requester 0 has top priority after reset; gap counter=0.
- States: IDLE, SEND, WAIT, HOLD.
- IDLE:
  - req_ready is combinational: one-hot on the first requester with req_valid=1, searching last_grant+1, +2, ... modulo NUM_REQ.
  - On accept: capture data and last; grant_id=winner; busy=1; go to SEND.
  - No valid requester: stay in IDLE, req_ready=0.
- SEND:
  - uart_send=1 for exactly this one cycle; uart_dintx = captured byte.
  - uart_dintx holds stable until the next capture.
  - Go to WAIT.
  - Latency: accept at cycle t gives uart_send at t+1.
- WAIT:
  - req_ready=0 to all requesters.
  - On uart_donetx=1:
    - if captured last=1: last_grant=grant_id, busy=0, go to IDLE;
    - else: clear the gap counter, go to HOLD.
  - uart_donetx is ignored in every state other than WAIT.
- HOLD:
  - req_ready[grant_id]=req_valid[grant_id]; other requesters get 0.
  - Owner byte accepted: capture data and last, go to SEND.
  - No owner byte: gap counter increments.
  - Counter reaches MAX_GAP-1 with no accept: gap_err pulses, last_grant=grant_id, busy=0, go to IDLE.
  - On revoke, the owner's next byte competes as a new burst.
- Fairness:
  - last_grant updates only on release, so a releasing requester has lowest priority in the next arbitration.
  - Other requesters' req_valid never preempt a burst.
- Simultaneous events:
  - Watchdog expiry in the same cycle as an owner accept: the accept wins, no gap_err.
  - Release from WAIT: the next grant is decided in IDLE on the following cycle, giving one idle cycle between bursts.
- A single-byte burst (last=1 on the first byte) releases after one frame.
- Reset asserted mid-frame: all state clears immediately.
  - The UART transmitter resets on the same reset; no partial burst resumes.
- grant_id holds its last value while busy=0.

Test Plan:
- Single requester: req 2 sends 8'hA5 with last=1 → req_ready[2] in cycle t, uart_send at t+1 with uart_dintx=8'hA5, busy falls the cycle after donetx.
- All 4 requesters valid continuously, 1-byte bursts → grant order 0,1,2,3,0 after reset; each uart_send carries the matching requester's byte.
- Burst lock: req 1 sends 3 bytes (11,22,33, last on 33) while req 0 is valid → three frames from req 1 back to back, then req 0 granted; no interleave.
- Watchdog: req 3 sends 1 non-last byte, then deasserts valid → gap_err pulses exactly MAX_GAP cycles after entering HOLD; busy=0; req 0 granted next if valid.
- Race: owner asserts valid in the exact expiry cycle → byte accepted, gap_err stays 0.
- Reset mid-WAIT: drive rst=0 → all outputs return to reset values asynchronously; after release, arbitration restarts at requester 0.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin owner-per-burst scheduler in front of a single UART transmitter.
// An inter-byte watchdog revokes the grant of an owner that stalls mid-burst.
module uart_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int MAX_GAP = 64,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_send,
    output logic [7:0]           uart_dintx,
    input  logic                 uart_donetx,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 gap_err
);

    localparam int GW = $clog2(MAX_GAP + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]               state;
    logic [ID_W-1:0]          last_grant;
    logic [ID_W-1:0]          winner;
    logic [ID_W-1:0]          cand;
    logic [ID_W-1:0]          sel;
    logic                     found;
    logic                     accept;
    logic                     last_q;
    logic [GW-1:0]            gap_cnt;
    logic [NUM_REQ-1:0][7:0]  data_arr;

    assign data_arr = req_data;

    // Search starts just after the last released owner, so it gets lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = last_grant;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        case (state)
            ST_IDLE: if (found) req_ready[winner] = 1'b1;
            ST_HOLD: req_ready[grant_id] = req_valid[grant_id];
            default: req_ready = '0;
        endcase
    end

    assign sel    = (state == ST_IDLE) ? winner : grant_id;
    assign accept = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            grant_id   <= '0;
            busy       <= 1'b0;
            gap_err    <= 1'b0;
            uart_send  <= 1'b0;
            uart_dintx <= 8'h00;
            last_q     <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            uart_send <= 1'b0;
            gap_err   <= 1'b0;
            case (state)
                ST_IDLE, ST_HOLD: begin
                    // An accept in the expiry cycle wins over the watchdog.
                    if (accept) begin
                        uart_dintx <= data_arr[sel];
                        last_q     <= req_last[sel];
                        grant_id   <= sel;
                        busy       <= 1'b1;
                        uart_send  <= 1'b1;
                        state      <= ST_SEND;
                    end else if (state == ST_HOLD) begin
                        if (gap_cnt == GW'(MAX_GAP - 1)) begin
                            gap_err    <= 1'b1;
                            last_grant <= grant_id;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                end
                ST_SEND: state <= ST_WAIT;
                ST_WAIT: begin
                    if (uart_donetx) begin
                        if (last_q) begin
                            last_grant <= grant_id;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= ST_HOLD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
